// File: rtl/serial_addsub_ctrl_if.sv
// Handshake and data bus of the bit-serial add/subtract sequencer.
// The requester drives start/op/operands; the sequencer drives the status
// decodes and the registered result.
interface serial_addsub_ctrl_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s_out;
   logic             cout;
   logic             ovf;

   modport master (
      output start, op, a_in, b_in,
      input  ready, busy, done, s_out, cout, ovf
   );

   modport slave (
      input  start, op, a_in, b_in,
      output ready, busy, done, s_out, cout, ovf
   );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer. One full-adder cell is reused over
// WIDTH cycles, LSB first. Carry-in is seeded from op so that increment and
// subtract (A + ~B + 1) reuse the same cell. Status outputs and result are
// registered; ready/busy/done mirror the FSM state one-for-one.
module serial_addsub_ctrl #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input logic                clk,
   input logic                rst,
   serial_addsub_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Carry out of a full adder.
   function automatic logic maj3(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             c_q, c_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             ready_q, busy_q, done_q;
   logic             sum_s;
   logic             carry_s;

   // Full-adder cell on the current LSBs and the stored carry.
   always_comb begin
      sum_s   = a_q[0] ^ b_q[0] ^ c_q;
      carry_s = maj3(a_q[0], b_q[0], c_q);
   end

   // Next-state and datapath: accept in IDLE, one bit per RUN cycle, single DONE cycle.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      s_d     = s_q;
      cnt_d   = cnt_q;
      c_d     = c_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               a_d     = bus.a_in;
               b_d     = bus.op[1] ? ~bus.b_in : bus.b_in;
               c_d     = bus.op[0] ^ bus.op[1];
               res_d   = '0;
               cnt_d   = '0;
               s_d     = '0;
               cout_d  = 1'b0;
               ovf_d   = 1'b0;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            a_d   = {1'b0, a_q[WIDTH-1:1]};
            b_d   = {1'b0, b_q[WIDTH-1:1]};
            res_d = {sum_s, res_q[WIDTH-1:1]};
            c_d   = carry_s;
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == LAST_CNT) begin
               // c_q here is the carry into the MSB.
               s_d     = {sum_s, res_q[WIDTH-1:1]};
               cout_d  = carry_s;
               ovf_d   = c_q ^ carry_s;
               state_d = ST_DONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM state register and registered status decodes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d == ST_IDLE);
         busy_q  <= (state_d == ST_RUN);
         done_q  <= (state_d == ST_DONE);
      end
   end

   // Datapath registers: operand shifters, carry, counter and result.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         res_q  <= '0;
         s_q    <= '0;
         cnt_q  <= '0;
         c_q    <= 1'b0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         res_q  <= res_d;
         s_q    <= s_d;
         cnt_q  <= cnt_d;
         c_q    <= c_d;
         cout_q <= cout_d;
         ovf_q  <= ovf_d;
      end
   end

   assign bus.ready = ready_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.s_out = s_q;
   assign bus.cout  = cout_q;
   assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl at WIDTH=8. Expected results come
// from a parallel arithmetic model and are queued at accept, then popped and
// compared when done is seen.
module tb_serial_addsub_ctrl;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   typedef struct packed {
      logic [WIDTH-1:0] s;
      logic             cout;
      logic             ovf;
   } exp_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;
   int   done_cnt;
   exp_t sb[$];

   serial_addsub_ctrl_if #(.WIDTH(WIDTH)) bus_if ();

   serial_addsub_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count done pulses (value seen in the cycle before each rising edge).
   always @(posedge clk) begin
      if (bus_if.done === 1'b1) done_cnt <= done_cnt + 1;
   end

   // Launch one operation at the current falling edge and check it end to end.
   task automatic do_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input bit inject, input string name);
      exp_t             e;
      exp_t             g;
      logic [WIDTH-1:0] bb;
      logic [WIDTH:0]   full;
      logic             cin;
      int               busy_n;
      int               done_k;
      int               dc0;
      bb     = op[1] ? ~b : b;
      cin    = op[0] ^ op[1];
      full   = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, cin};
      e.s    = full[WIDTH-1:0];
      e.cout = full[WIDTH];
      e.ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
      sb.push_back(e);
      n_cmp++;
      if (bus_if.ready !== 1'b1) begin
         n_err++;
         $display("FAIL %s ready_before_start: got %b expected 1", name, bus_if.ready);
      end
      dc0            = done_cnt;
      bus_if.start   = 1'b1;
      bus_if.op      = op;
      bus_if.a_in    = a;
      bus_if.b_in    = b;
      @(negedge clk);
      bus_if.start   = 1'b0;
      bus_if.op      = ~op;
      bus_if.a_in    = WIDTH'($urandom);
      bus_if.b_in    = WIDTH'($urandom);
      n_cmp++;
      if ({bus_if.s_out, bus_if.cout, bus_if.ovf} !== {(WIDTH + 2){1'b0}}) begin
         n_err++;
         $display("FAIL %s clear_on_accept: got s=%h c=%b v=%b expected 0", name,
                  bus_if.s_out, bus_if.cout, bus_if.ovf);
      end
      busy_n = 0;
      done_k = -1;
      for (int k = 0; k <= WIDTH + 4; k++) begin
         if (bus_if.done === 1'b1) begin
            done_k = k;
            break;
         end
         if (bus_if.busy === 1'b1) busy_n++;
         if (inject && k == 2) begin
            bus_if.start = 1'b1;
            bus_if.a_in  = {WIDTH{1'b1}};
            bus_if.b_in  = {WIDTH{1'b1}};
         end
         if (inject && k == 5) bus_if.start = 1'b0;
         @(negedge clk);
      end
      n_cmp++;
      if (done_k != WIDTH) begin
         n_err++;
         $display("FAIL %s latency: got %0d expected %0d", name, done_k, WIDTH);
      end
      n_cmp++;
      if (busy_n != WIDTH) begin
         n_err++;
         $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_n, WIDTH);
      end
      g.s    = bus_if.s_out;
      g.cout = bus_if.cout;
      g.ovf  = bus_if.ovf;
      if (sb.size() > 0) e = sb.pop_front();
      n_cmp++;
      if (g.s !== e.s) begin
         n_err++;
         $display("FAIL %s s_out: got %h expected %h", name, g.s, e.s);
      end
      n_cmp++;
      if (g.cout !== e.cout) begin
         n_err++;
         $display("FAIL %s cout: got %b expected %b", name, g.cout, e.cout);
      end
      n_cmp++;
      if (g.ovf !== e.ovf) begin
         n_err++;
         $display("FAIL %s ovf: got %b expected %b", name, g.ovf, e.ovf);
      end
      @(negedge clk);
      n_cmp++;
      if ({bus_if.done, bus_if.ready, bus_if.busy} !== 3'b010) begin
         n_err++;
         $display("FAIL %s after_done: got done/ready/busy=%b%b%b expected 010", name,
                  bus_if.done, bus_if.ready, bus_if.busy);
      end
      n_cmp++;
      if (bus_if.s_out !== e.s) begin
         n_err++;
         $display("FAIL %s s_out_hold: got %h expected %h", name, bus_if.s_out, e.s);
      end
      n_cmp++;
      if (done_cnt - dc0 != 1) begin
         n_err++;
         $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt - dc0);
      end
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      bus_if.start = 1'b0;
      bus_if.op    = 2'b00;
      bus_if.a_in  = '0;
      bus_if.b_in  = '0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({bus_if.ready, bus_if.busy, bus_if.done} !== 3'b100) begin
         n_err++;
         $display("FAIL reset_status: got ready/busy/done=%b%b%b expected 100",
                  bus_if.ready, bus_if.busy, bus_if.done);
      end
      n_cmp++;
      if ({bus_if.s_out, bus_if.cout, bus_if.ovf} !== {(WIDTH + 2){1'b0}}) begin
         n_err++;
         $display("FAIL reset_outputs: got s=%h c=%b v=%b expected 0",
                  bus_if.s_out, bus_if.cout, bus_if.ovf);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_arith();
      do_op(2'b00, 8'h35, 8'h4A, 1'b0, "add_basic");
      do_op(2'b01, 8'hFF, 8'h00, 1'b0, "inc_wrap");
      do_op(2'b00, 8'h7F, 8'h01, 1'b0, "add_ovf");
      do_op(2'b10, 8'h10, 8'h20, 1'b0, "sub_borrow");
      do_op(2'b10, 8'h80, 8'h01, 1'b0, "sub_ovf");
   endtask

   task automatic test_back_to_back();
      do_op(2'b11, 8'h05, 8'h05, 1'b0, "subdec");
      do_op(2'b00, 8'h01, 8'h01, 1'b0, "b2b_add");
   endtask

   task automatic test_ignore_start();
      do_op(2'b00, 8'h35, 8'h4A, 1'b1, "start_in_run");
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) begin
         do_op(2'($urandom), WIDTH'($urandom), WIDTH'($urandom), 1'b0, "random");
      end
   endtask

   task automatic test_reset_abort();
      int dc0;
      dc0          = done_cnt;
      bus_if.start = 1'b1;
      bus_if.op    = 2'b00;
      bus_if.a_in  = 8'h35;
      bus_if.b_in  = 8'h4A;
      @(negedge clk);
      bus_if.start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if ({bus_if.ready, bus_if.busy, bus_if.done} !== 3'b100) begin
         n_err++;
         $display("FAIL abort_status: got ready/busy/done=%b%b%b expected 100",
                  bus_if.ready, bus_if.busy, bus_if.done);
      end
      n_cmp++;
      if ({bus_if.s_out, bus_if.cout, bus_if.ovf} !== {(WIDTH + 2){1'b0}}) begin
         n_err++;
         $display("FAIL abort_outputs: got s=%h c=%b v=%b expected 0",
                  bus_if.s_out, bus_if.cout, bus_if.ovf);
      end
      repeat (WIDTH + 4) @(negedge clk);
      n_cmp++;
      if (done_cnt != dc0) begin
         n_err++;
         $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt - dc0);
      end
      rst          = 1'b1;
      bus_if.start = 1'b1;
      @(negedge clk);
      rst          = 1'b0;
      bus_if.start = 1'b0;
      n_cmp++;
      if ({bus_if.ready, bus_if.busy} !== 2'b10) begin
         n_err++;
         $display("FAIL start_with_rst: got ready/busy=%b%b expected 10",
                  bus_if.ready, bus_if.busy);
      end
      @(negedge clk);
      n_cmp++;
      if ({bus_if.ready, bus_if.busy} !== 2'b10) begin
         n_err++;
         $display("FAIL start_with_rst_next: got ready/busy=%b%b expected 10",
                  bus_if.ready, bus_if.busy);
      end
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      done_cnt = 0;
      rst      = 1'b1;
      test_reset();
      test_arith();
      test_back_to_back();
      test_ignore_start();
      test_random();
      test_reset_abort();
      do_op(2'b10, 8'h05, 8'h03, 1'b0, "after_abort");
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/serial_addsub_ctrl.md
Name: serial_addsub_ctrl

Overview:
- Bit-serial add/subtract sequencer. It reuses one 1-bit full-adder cell over WIDTH cycles instead of a WIDTH-bit ripple chain.
- Controls the carry-in seeding, including the carry-in-1 mode used by the increment and subtract paths.
- Sequences operand shifting, carry storage, result assembly and the start/done handshake.
- Serves as the area-minimal alternative to the parallel adders in the adder library.

Parameters:
- WIDTH, 16, operand and result width in bits (>= 2).
- CNT_W, 5, counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when ready=1.
- op  input  2  00: A+B, 01: A+B+1, 10: A-B (A+~B+1), 11: A-B-1 (A+~B+0).
- a_in  input  WIDTH  operand A, captured on an accepted start.
- b_in  input  WIDTH  operand B, captured on an accepted start.
- ready  output  1  high in IDLE only.
- busy  output  1  high in RUN only.
- done  output  1  one-cycle pulse, high in DONE state.
- s_out  output  WIDTH  result; holds until the next accepted start or reset.
- cout  output  1  final carry out; for op 10/11, 1 = no borrow.
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous and active-high on rst.
  - While rst=1 at a clock edge: state <= IDLE; s_out, cout, ovf, done, busy <= 0; internal shift registers, carry and counter <= 0; ready=1 from the following cycle.
  - rst has priority over every other input, including a start in the same cycle.
- FSM: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - ready=1.
  - On start=1:
    - Latch a_in into A shift register.
    - Latch b_in into B shift register, inverted when op[1]=1.
    - Carry register <= op[0] XOR op[1], which gives cin 0/1/1/0 for op 00/01/10/11.
    - Counter <= 0; clear s_out, cout and ovf; go to RUN.
  - Operands are not required to be stable after the accept cycle.
- RUN: one bit per cycle, LSB first.
  - Sum bit = A[0]^B[0]^c.
  - c <= majority(A[0], B[0], c).
  - Sum bit shifts into the result MSB, result shifts right; A and B shift right.
  - Counter increments each cycle.
  - On the cycle processing bit WIDTH-1 (counter = WIDTH-1):
    - Record the carry into that bit as c_msb_in.
    - cout <= carry out; ovf <= c_msb_in ^ carry out.
    - Go to DONE.
- DONE:
  - done=1 for exactly one cycle; s_out, cout and ovf are valid and stable.
  - Next cycle returns to IDLE.
- Latency: start accepted at edge T; done high in the cycle after edge T+WIDTH. Throughput is one operation per WIDTH+2 cycles.
- start while busy=1 or done=1 is ignored: no re-latch, no effect on the in-flight result, no queueing.
- rst mid-RUN aborts the operation: no done pulse, outputs cleared.
- op is sampled only at accept. Changing op during RUN has no effect.
- Outputs are registered. No combinational path from inputs to outputs except none (ready, busy and done are state decodes).

Test Plan:
1. WIDTH=8, op=00, A=0x35, B=0x4A, start pulse at edge T -> done high the cycle after edge T+8; s_out=0x7F, cout=0, ovf=0; busy high for 8 cycles.
2. op=01, A=0xFF, B=0x00 -> s_out=0x00, cout=1, ovf=0. Also op=00, A=0x7F, B=0x01 -> s_out=0x80, cout=0, ovf=1.
3. op=10, A=0x10, B=0x20 -> s_out=0xF0, cout=0 (borrow), ovf=0. Also op=10, A=0x80, B=0x01 -> s_out=0x7F, cout=1, ovf=1.
4. op=11, A=0x05, B=0x05 -> s_out=0xFF, cout=0, ovf=0. Immediately after done, start op=00 with A=0x01, B=0x01 -> accepted in IDLE; s_out=0x02 after the full latency.
5. Start A=0x35, B=0x4A, op=00; during RUN drive start=1 with A=0xFF, B=0xFF -> ignored; final s_out=0x7F; exactly one done pulse.
6. Start any operation; assert rst for one cycle at the 3rd RUN cycle -> next cycle ready=1, busy=0, s_out=0, cout=0, ovf=0; no done pulse. Start asserted together with rst -> not accepted.
